sw_out_arbiter: RTL and testbench

Output-port scheduler for the switch. It shares one egress port among NUM_REQ input FIFOs (fifo_mem instances) using round-robin arbitration at packet granularity. It drives each FIFO's rd_en, muxes the granted FIFO's data_out onto the egress bus, and frames the transfer with valid/sop/eop. It sits between the per-input FIFOs and the egress port logic.

---
 rtl/sw_pkg.sv | 25 ++
 rtl/sw_rr_arbiter.sv | 24 ++
 rtl/sw_out_arbiter.sv | 127 ++++++++++++
 tb/tb_sw_out_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared types and helpers for the switch output-port scheduler.
package sw_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, XFER, LAST} state_t;

  localparam int MAX_REQ = 8;

  // Round-robin winner: first requester at or after ptr, wrapping modulo n.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int unsigned ptr,
                                         input int unsigned n);
    logic       found;
    logic [2:0] idx;
    rr_pick = 3'(ptr);
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((ptr + i) % n);
      if (!found && (i < n) && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sw_rr_arbiter.sv
// Combinational round-robin pick; the pointer is owned by the parent.
module sw_rr_arbiter
  import sw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
  end

  assign winner = SEL_W'(rr_pick(req_ext, 32'(rr_ptr), 32'(NUM_REQ)));
  assign any    = |req;

endmodule

// File: rtl/sw_out_arbiter.sv
// Egress scheduler: packet-granular round-robin over NUM_REQ FIFOs, framing with valid/sop/eop.
module sw_out_arbiter
  import sw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*W_WIDTH-1:0] req_len,
  input  logic [NUM_REQ*W_WIDTH-1:0] fifo_data,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         rd_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [W_WIDTH-1:0]         data_out,
  output logic                       data_valid,
  output logic                       sop,
  output logic                       eop,
  output logic                       len_err
);

  localparam int SEL_W = $clog2(NUM_REQ);

  state_t               state_ff, state_nxt;
  logic [SEL_W-1:0]     sel_ff, sel_nxt;
  logic [SEL_W-1:0]     rr_ptr_ff, rr_ptr_nxt;
  logic [W_WIDTH-1:0]   cnt_ff, cnt_nxt;
  logic                 first_ff, first_nxt;
  logic                 dv_ff, sop_ff, eop_ff;
  logic [SEL_W-1:0]     winner;
  logic                 any;
  logic [W_WIDTH-1:0]   len_arr  [NUM_REQ];
  logic [W_WIDTH-1:0]   data_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      len_arr[i]  = req_len[i*W_WIDTH +: W_WIDTH];
      data_arr[i] = fifo_data[i*W_WIDTH +: W_WIDTH];
    end
  end

  sw_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_ff),
    .winner (winner),
    .any    (any)
  );

  // Winner, pointer and length are captured on entry to GRANT so req changes afterwards are ignored.
  always_comb begin
    state_nxt  = state_ff;
    sel_nxt    = sel_ff;
    rr_ptr_nxt = rr_ptr_ff;
    cnt_nxt    = cnt_ff;
    first_nxt  = first_ff;
    gnt        = '0;
    rd_en      = '0;
    len_err    = 1'b0;
    case (state_ff)
      IDLE: begin
        if (any) begin
          state_nxt  = GRANT;
          sel_nxt    = winner;
          cnt_nxt    = len_arr[winner];
          rr_ptr_nxt = (winner == SEL_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
      end
      GRANT: begin
        gnt       = NUM_REQ'(1) << sel_ff;
        first_nxt = 1'b1;
        if (cnt_ff == '0) begin
          len_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        gnt = NUM_REQ'(1) << sel_ff;
        if (out_ready) begin
          rd_en     = NUM_REQ'(1) << sel_ff;
          cnt_nxt   = cnt_ff - 1'b1;
          first_nxt = 1'b0;
          if (cnt_ff == W_WIDTH'(1)) state_nxt = LAST;
        end
      end
      LAST: begin
        gnt       = NUM_REQ'(1) << sel_ff;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_ff  <= IDLE;
      sel_ff    <= '0;
      rr_ptr_ff <= '0;
      cnt_ff    <= '0;
      first_ff  <= 1'b0;
      dv_ff     <= 1'b0;
      sop_ff    <= 1'b0;
      eop_ff    <= 1'b0;
    end else begin
      state_ff  <= state_nxt;
      sel_ff    <= sel_nxt;
      rr_ptr_ff <= rr_ptr_nxt;
      cnt_ff    <= cnt_nxt;
      first_ff  <= first_nxt;
      dv_ff     <= |rd_en;
      sop_ff    <= (|rd_en) & first_ff;
      eop_ff    <= (|rd_en) & (cnt_ff == W_WIDTH'(1));
    end
  end

  // FIFO data arrives one cycle after rd_en, aligned with the delayed valid.
  assign data_valid = dv_ff;
  assign sop        = sop_ff;
  assign eop        = eop_ff;
  assign data_out   = dv_ff ? data_arr[sel_ff] : '0;

endmodule

// File: tb/tb_sw_out_arbiter.sv
// Directed self-checking bench for sw_out_arbiter with a behavioural fifo_mem model.
module tb_sw_out_arbiter;
  import sw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic [31:0] fifo_data;
  logic        out_ready;
  logic [3:0]  rd_en;
  logic [3:0]  gnt;
  logic [7:0]  data_out;
  logic        data_valid, sop, eop, len_err;

  int checks = 0;
  int errors = 0;

  sw_out_arbiter #(
    .NUM_REQ (4),
    .W_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .fifo_data  (fifo_data),
    .out_ready  (out_ready),
    .rd_en      (rd_en),
    .gnt        (gnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sop        (sop),
    .eop        (eop),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  // fifo_mem model: one-cycle read latency, zero when not read.
  logic [7:0] mem  [4][16];
  logic [3:0] rptr [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data <= '0;
      for (int i = 0; i < 4; i++) rptr[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rd_en[i]) begin
          fifo_data[i*8 +: 8] <= mem[i][rptr[i]];
          rptr[i]             <= rptr[i] + 4'd1;
        end else begin
          fifo_data[i*8 +: 8] <= '0;
        end
      end
    end
  end

  // Monitor: owns all logs and counters, sampled mid-cycle.
  int          cyc = 0;
  logic [9:0]  cap[$];
  int          gnt_log[$];
  int          rd_cnt = 0, gnt_cyc = 0, lerr_cnt = 0;
  int          gnt_rise_cyc = 0, sop_cyc = 0, eop_cyc = 0;
  logic [3:0]  prev_gnt = '0;

  function automatic int oh2idx(input logic [3:0] v);
    oh2idx = -1;
    for (int i = 0; i < 4; i++) if (v[i]) oh2idx = i;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) cap.push_back({sop, eop, data_out});
      if (data_valid && sop) sop_cyc = cyc;
      if (data_valid && eop) eop_cyc = cyc;
      rd_cnt = rd_cnt + $countones(rd_en);
      if (gnt != 0) gnt_cyc = gnt_cyc + 1;
      if (gnt != 0 && prev_gnt == 0) begin
        gnt_log.push_back(oh2idx(gnt));
        gnt_rise_cyc = cyc;
      end
      if (len_err) lerr_cnt = lerr_cnt + 1;
      prev_gnt = gnt;
    end else begin
      prev_gnt = '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives one request pattern for ncyc cycles; stall bit k holds out_ready low in relative cycle k.
  task automatic run(input logic [3:0] r, input logic [31:0] lens, input int ncyc,
                     input logic [31:0] stall);
    req     = r;
    req_len = lens;
    for (int k = 0; k < ncyc; k++) begin
      out_ready = ~stall[k];
      if (gnt != 0) req = '0;
      tick();
    end
    req       = '0;
    out_ready = 1'b1;
  endtask

  int c0, cb, rb, gb, gcb, lb;

  initial begin
    rst_n = 1'b0; req = '0; req_len = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) mem[i][k] = 8'(i * 16 + k);
    #1;
    check("rst_outs", {20'd0, rd_en, gnt, data_valid, sop, eop, len_err}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single packet, requester 2, three words.
    mem[2][0] = 8'hA1; mem[2][1] = 8'hA2; mem[2][2] = 8'hA3;
    c0 = cyc; cb = cap.size(); rb = rd_cnt; gcb = gnt_cyc;
    run(4'b0100, 32'h0003_0000, 10, 32'd0);
    check("single_rd_cnt",  32'(rd_cnt - rb), 32'd3);
    check("single_gnt_cyc", 32'(gnt_cyc - gcb), 32'd5);
    check("single_nwords",  32'(cap.size() - cb), 32'd3);
    check("single_w1", 32'(cap[cb]),   {22'd0, 2'b10, 8'hA1});
    check("single_w2", 32'(cap[cb+1]), {22'd0, 2'b00, 8'hA2});
    check("single_w3", 32'(cap[cb+2]), {22'd0, 2'b01, 8'hA3});
    check("lat_gnt", 32'(gnt_rise_cyc - c0), 32'd1);
    check("lat_sop", 32'(sop_cyc - c0), 32'd3);
    check("lat_eop", 32'(eop_cyc - c0), 32'd5);

    // Round-robin fairness with all four requesting, then a sparse pattern.
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) mem[i][k] = 8'(i * 16 + k);
    gb = gnt_log.size(); cb = cap.size();
    req = 4'b1111; req_len = 32'h0202_0202; out_ready = 1'b1;
    for (int k = 0; k < 80 && gnt_log.size() < gb + 5; k++) tick();
    req = 4'b1010;
    for (int k = 0; k < 80 && gnt_log.size() < gb + 8; k++) tick();
    check("rr_ngrants", 32'(gnt_log.size() - gb), 32'd8);
    req = '0;
    for (int k = 0; k < 10; k++) tick();
    begin
      int exp_order [8] = '{0, 1, 2, 3, 0, 1, 3, 1};
      for (int i = 0; i < 8; i++)
        check($sformatf("rr_order%0d", i),
              (gnt_log.size() > gb + i) ? 32'(gnt_log[gb+i]) : 32'hFFFF_FFFF,
              32'(exp_order[i]));
    end
    check("rr_nwords", 32'(cap.size() - cb), 32'd16);
    check("rr_w_first", 32'(cap[cb]),   {22'd0, 2'b10, 8'h00});
    check("rr_w_gnt1",  32'(cap[cb+2]), {22'd0, 2'b10, 8'h10});

    // Backpressure: out_ready low in the 2nd and 4th XFER cycles.
    do_reset();
    mem[0][0] = 8'hB1; mem[0][1] = 8'hB2; mem[0][2] = 8'hB3; mem[0][3] = 8'hB4;
    cb = cap.size(); rb = rd_cnt;
    run(4'b0001, 32'h0000_0004, 12, 32'h0000_0028);
    check("bp_rd_cnt", 32'(rd_cnt - rb), 32'd4);
    check("bp_nwords", 32'(cap.size() - cb), 32'd4);
    check("bp_w1", 32'(cap[cb]),   {22'd0, 2'b10, 8'hB1});
    check("bp_w2", 32'(cap[cb+1]), {22'd0, 2'b00, 8'hB2});
    check("bp_w3", 32'(cap[cb+2]), {22'd0, 2'b00, 8'hB3});
    check("bp_w4", 32'(cap[cb+3]), {22'd0, 2'b01, 8'hB4});

    // Zero length on requester 1, then 1 and 2 both request.
    do_reset();
    cb = cap.size(); rb = rd_cnt; lb = lerr_cnt;
    run(4'b0010, 32'h0000_0000, 6, 32'd0);
    check("zl_lerr",   32'(lerr_cnt - lb), 32'd1);
    check("zl_rd",     32'(rd_cnt - rb), 32'd0);
    check("zl_nwords", 32'(cap.size() - cb), 32'd0);
    check("zl_gnt",    32'(gnt_log[gnt_log.size()-1]), 32'd1);
    lb = lerr_cnt; cb = cap.size();
    run(4'b0110, 32'h0002_0000, 10, 32'd0);
    check("zl_next_gnt", 32'(gnt_log[gnt_log.size()-1]), 32'd2);
    check("zl_next_words", 32'(cap.size() - cb), 32'd2);
    check("zl_next_lerr", 32'(lerr_cnt - lb), 32'd0);

    // One-word packet, then reset in the middle of a five-word packet.
    do_reset();
    mem[3][0] = 8'hC1;
    for (int k = 0; k < 5; k++) mem[0][k] = 8'(8'hD1 + k);
    cb = cap.size();
    run(4'b1000, 32'h0100_0000, 8, 32'd0);
    check("one_nwords", 32'(cap.size() - cb), 32'd1);
    check("one_w", 32'(cap[cb]), {22'd0, 2'b11, 8'hC1});
    cb = cap.size();
    req = 4'b0001; req_len = 32'h0000_0005; out_ready = 1'b1;
    for (int k = 0; k < 20 && cap.size() < cb + 2; k++) begin
      if (gnt != 0) req = '0;
      tick();
    end
    req = '0;
    check("abort_words", 32'(cap.size() - cb), 32'd2);
    check("abort_pre_gnt", {28'd0, gnt}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {20'd0, rd_en, gnt, data_valid, sop, eop, len_err}, 32'd0);
    check("abort_data", {24'd0, data_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_state", 32'(dut.state_ff), 32'(IDLE));
    check("abort_rrptr", 32'(dut.rr_ptr_ff), 32'd0);
    run(4'b1111, 32'h0101_0101, 6, 32'd0);
    check("abort_next_gnt", 32'(gnt_log[gnt_log.size()-1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
